mvu_seq: RTL and testbench
==========================

Name: mvu_seq

Overview:
- Upstream sequencer for the matrix-vector unit. It runs one bit-serial matrix-vector job.
- It generates the weight BRAM read address (Raddr) and the input-buffer read address/enable.
- It drives the MVU accumulator controls (clr, sh, mulmode), aligned to the 1-cycle BRAM read latency.
- Loop nest: significance level k (MSB first), then weight/input bit pairs with b+j=k, then len row-chunks. When the job ends, the MVU O bus holds the full-precision dot products.

Parameters:
- AW, 9, address width of weight BRAM and input buffer (matches the MVU Raddr width)
- PW, 4, width of the precision fields; precision = field+1 bits, so 1..16

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  job request; sampled only in IDLE
- wprec  input  PW  weight precision minus 1
- iprec  input  PW  input precision minus 1
- wsigned  input  1  weights are two's complement (bit wprec is the sign bit)
- isigned  input  1  inputs are two's complement (bit iprec is the sign bit)
- len  input  AW  row-chunks per bit-plane
- wbase  input  AW  weight bit-plane 0, chunk 0 address
- ibase  input  AW  input bit-plane 0, chunk 0 address
- busy  output  1  job in progress
- done  output  1  single-cycle pulse; O is valid from this cycle
- Raddr  output  AW  weight BRAM read address
- iaddr  output  AW  input buffer read address
- ird  output  1  input buffer read enable
- clr  output  1  accumulator clear
- sh  output  1  shift accumulator left 1 before adding
- mulmode  output  2  00 idle/zero sum, 01 add product, 10 subtract product, 11 reserved (never driven)

Behaviour:
- Clock and reset: one clock clk; reset rst_n is synchronous, active-low. Reset takes effect at the next edge from any state, including mid-job.
- Reset values: IDLE; busy=0, done=0, clr=0, sh=0, mulmode=00, ird=0, Raddr=0, iaddr=0. No done pulse is produced for an aborted job.
- Job inputs are latched on the start edge. Later changes to them have no effect on the running job.
- FSM IDLE -> CLEAR: when start=1.
- FSM CLEAR: one cycle, clr=1, busy=1. Next state is RUN, or DRAIN if len=0.
- FSM RUN: issues one read per cycle.
  - Raddr = wbase + b*len + c
  - iaddr = ibase + j*len + c
  - ird = 1
  - Address sums wrap modulo 2^AW.
- Issue order within RUN:
  - k counts from wprec+iprec down to 0.
  - Within each k, b counts down from min(wprec,k) while j=k-b stays ≤ iprec.
  - c counts 0..len-1.
  - After the last issue the FSM goes to DRAIN.
- Control alignment: sh and mulmode for an issue at cycle t are driven at t+1 (registered delay line). At t+1 the BRAM data is present and the MVU accumulates.
- sh=1 only on the first issue of each level k, excluding the first level. sh=0 otherwise.
- Sign rule per issue: neg = (wsigned & b==wprec) XOR (isigned & j==iprec). mulmode = neg ? 10 : 01.
- Outside delayed issues, mulmode=00 and sh=0, so accumulators hold.
- FSM DRAIN: one cycle; the last accumulate lands.
- FSM DONE: done=1 for one cycle, busy=0 from this cycle. Next state is IDLE.
- start arriving in DONE or any busy state is ignored (not queued).
- Cycle count from the start edge to the done cycle: 3 + len*P, where P = number of (b,j) pairs = (wprec+1)*(iprec+1).
- Back-to-back jobs: start may be asserted in the cycle after done.

Decomposition:
- Shared package mvu_pkg:
  - mulmode encodings (MM_IDLE, MM_ADD, MM_SUB)
  - AW and PW defaults
  - FSM state enum
- Sub-module mvu_seq_idx: the (k,b,j,c) counter nest with first-of-level and last flags. The top keeps the FSM, address arithmetic and the 1-cycle control delay line.

Test Plan:
- 1x1-bit, unsigned, len=1, wbase=5, ibase=7, start at cycle 0 ->
  - cycle 1: clr=1
  - cycle 2: Raddr=5, iaddr=7, ird=1
  - cycle 3: mulmode=01, sh=0
  - cycle 4: done=1, busy=0
- 2x2-bit, unsigned, len=1, bases 0 ->
  - Raddr 1,1,0,0
  - iaddr 1,0,1,0
  - delayed sh 0,1,0,1
  - mulmode 01 x4
  - done at cycle 7
- 2x2-bit, both signed, same order -> mulmode 01,10,10,01.
- 2x3-bit, len=3, wbase=510 -> 18 issues; Raddr wraps 510,511,0 for plane 0; done at cycle 21.
- len=0 -> clr at cycle 1, done at cycle 3, no ird and no mulmode≠00.
- rst_n=0 mid-RUN -> next edge all outputs reset and no done. Also: start pulsed while busy is ignored; a start in the cycle after done launches a new job.
- End-to-end with the MVU and a reference model: random 4x4-bit signed data, n=64 -> O matches the integer matrix-vector product.

Source files
------------

// File: rtl/mvu_pkg.sv
// Shared definitions for the matrix-vector unit sequencer: default widths,
// accumulator mulmode encodings and the sequencer FSM state type.
package mvu_pkg;

  localparam int AW_DEF = 9;
  localparam int PW_DEF = 4;

  localparam logic [1:0] MM_IDLE = 2'b00;
  localparam logic [1:0] MM_ADD  = 2'b01;
  localparam logic [1:0] MM_SUB  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } mvu_state_e;

endpackage

// File: rtl/mvu_seq_if.sv
// Job request / BRAM read / accumulator control bundle between a host and the
// sequencer. The sequencer side is the slave modport.
interface mvu_seq_if import mvu_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int PW = PW_DEF
);
  logic          start;
  logic [PW-1:0] wprec;
  logic [PW-1:0] iprec;
  logic          wsigned;
  logic          isigned;
  logic [AW-1:0] len;
  logic [AW-1:0] wbase;
  logic [AW-1:0] ibase;
  logic          busy;
  logic          done;
  logic [AW-1:0] Raddr;
  logic [AW-1:0] iaddr;
  logic          ird;
  logic          clr;
  logic          sh;
  logic [1:0]    mulmode;

  modport master (
    output start, wprec, iprec, wsigned, isigned, len, wbase, ibase,
    input  busy, done, Raddr, iaddr, ird, clr, sh, mulmode
  );

  modport slave (
    input  start, wprec, iprec, wsigned, isigned, len, wbase, ibase,
    output busy, done, Raddr, iaddr, ird, clr, sh, mulmode
  );
endinterface

// File: rtl/mvu_seq_idx.sv
// (k, b, j, c) loop nest for one bit-serial job: level k MSB first, weight bit b
// descending with j = k - b, row-chunk c ascending. Flags first-of-level and last.
module mvu_seq_idx import mvu_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [PW-1:0] wprec,
  input  logic [PW-1:0] iprec,
  input  logic [AW-1:0] len,
  output logic [PW-1:0] b,
  output logic [PW-1:0] j,
  output logic [AW-1:0] c,
  output logic          first,
  output logic          last
);
  localparam logic [AW-1:0] ONE_A = AW'(1);
  localparam logic [PW:0]   ONE_K = (PW+1)'(1);

  logic [PW-1:0] wp_q, wp_d, ip_q, ip_d, b_q, b_d, j_q, j_d, bn_s;
  logic [PW:0]   k_q, k_d, kmax_s, kn_s, jn_s;
  logic [AW-1:0] len_q, len_d, c_q, c_d;

  // Highest weight bit that can pair with some input bit at level k.
  function automatic logic [PW-1:0] top_b(input logic [PW:0] k, input logic [PW-1:0] wp);
    if (k > {1'b0, wp}) begin
      return wp;
    end else begin
      return k[PW-1:0];
    end
  endfunction

  // Next-index computation: load a fresh nest or advance it by one issue.
  always_comb begin
    kmax_s = {1'b0, wp_q} + {1'b0, ip_q};
    kn_s   = k_q - ONE_K;
    bn_s   = top_b(kn_s, wp_q);
    jn_s   = kn_s - {1'b0, bn_s};
    wp_d   = wp_q;
    ip_d   = ip_q;
    len_d  = len_q;
    k_d    = k_q;
    b_d    = b_q;
    j_d    = j_q;
    c_d    = c_q;
    if (load) begin
      wp_d  = wprec;
      ip_d  = iprec;
      len_d = len;
      k_d   = {1'b0, wprec} + {1'b0, iprec};
      b_d   = wprec;
      j_d   = iprec;
      c_d   = '0;
    end else if (step) begin
      if (c_q != len_q - ONE_A) begin
        c_d = c_q + ONE_A;
      end else begin
        c_d = '0;
        if ((b_q != '0) && (j_q != ip_q)) begin
          b_d = b_q - PW'(1);
          j_d = j_q + PW'(1);
        end else begin
          k_d = kn_s;
          b_d = bn_s;
          j_d = jn_s[PW-1:0];
        end
      end
    end else begin
      c_d = c_q;
    end
  end

  // Index registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q  <= '0;
      ip_q  <= '0;
      len_q <= '0;
      k_q   <= '0;
      b_q   <= '0;
      j_q   <= '0;
      c_q   <= '0;
    end else begin
      wp_q  <= wp_d;
      ip_q  <= ip_d;
      len_q <= len_d;
      k_q   <= k_d;
      b_q   <= b_d;
      j_q   <= j_d;
      c_q   <= c_d;
    end
  end

  assign b     = b_q;
  assign j     = j_q;
  assign c     = c_q;
  assign last  = (k_q == '0) && (c_q == len_q - ONE_A);
  assign first = (c_q == '0) && (b_q == top_b(k_q, wp_q)) && (k_q != kmax_s);

endmodule

// File: rtl/mvu_seq.sv
// Sequencer for one bit-serial matrix-vector job: FSM, BRAM/input-buffer address
// generation and the one-cycle delay line that aligns sh/mulmode with read data.
module mvu_seq import mvu_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int PW = PW_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  mvu_seq_if.slave bus
);
  mvu_state_e    state_q, state_d;
  logic [PW-1:0] wprec_q, wprec_d, iprec_q, iprec_d;
  logic          wsigned_q, wsigned_d, isigned_q, isigned_d;
  logic [AW-1:0] len_q, len_d, wbase_q, wbase_d, ibase_q, ibase_d;
  logic [AW-1:0] raddr_q, raddr_d, iaddr_q, iaddr_d;
  logic          busy_q, busy_d, done_q, done_d, clr_q, clr_d;
  logic          ird_q, ird_d, sh_q, sh_d;
  logic [1:0]    mulmode_q, mulmode_d;
  logic          iss_neg_q, iss_neg_d, iss_sh_q, iss_sh_d, iss_last_q, iss_last_d;
  logic          load_s, issue_s, neg_s, idx_first_s, idx_last_s;
  logic [PW-1:0] idx_b_s, idx_j_s;
  logic [AW-1:0] idx_c_s;

  assign load_s  = (state_q == ST_IDLE) && bus.start;
  assign issue_s = ((state_q == ST_CLEAR) && (len_q != '0)) ||
                   ((state_q == ST_RUN) && !iss_last_q);
  assign neg_s   = (wsigned_q && (idx_b_s == wprec_q)) ^ (isigned_q && (idx_j_s == iprec_q));

  mvu_seq_idx #(.AW(AW), .PW(PW)) u_idx (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_s),
    .step  (issue_s),
    .wprec (bus.wprec),
    .iprec (bus.iprec),
    .len   (bus.len),
    .b     (idx_b_s),
    .j     (idx_j_s),
    .c     (idx_c_s),
    .first (idx_first_s),
    .last  (idx_last_s)
  );

  // FSM next state, job latch, read issue and delayed accumulator controls.
  always_comb begin
    state_d    = state_q;
    wprec_d    = wprec_q;
    iprec_d    = iprec_q;
    wsigned_d  = wsigned_q;
    isigned_d  = isigned_q;
    len_d      = len_q;
    wbase_d    = wbase_q;
    ibase_d    = ibase_q;
    raddr_d    = raddr_q;
    iaddr_d    = iaddr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    clr_d      = 1'b0;
    ird_d      = issue_s;
    iss_neg_d  = iss_neg_q;
    iss_sh_d   = iss_sh_q;
    iss_last_d = iss_last_q;
    // The issue of the previous cycle is accumulated now that its data is out of BRAM.
    sh_d       = ird_q && iss_sh_q;
    mulmode_d  = ird_q ? (iss_neg_q ? MM_SUB : MM_ADD) : MM_IDLE;
    if (issue_s) begin
      raddr_d    = wbase_q + AW'(idx_b_s) * len_q + idx_c_s;
      iaddr_d    = ibase_q + AW'(idx_j_s) * len_q + idx_c_s;
      iss_neg_d  = neg_s;
      iss_sh_d   = idx_first_s;
      iss_last_d = idx_last_s;
    end else begin
      iss_last_d = iss_last_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_CLEAR;
          busy_d    = 1'b1;
          clr_d     = 1'b1;
          wprec_d   = bus.wprec;
          iprec_d   = bus.iprec;
          wsigned_d = bus.wsigned;
          isigned_d = bus.isigned;
          len_d     = bus.len;
          wbase_d   = bus.wbase;
          ibase_d   = bus.ibase;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_d = (len_q == '0) ? ST_DRAIN : ST_RUN;
      end
      ST_RUN: begin
        if (iss_last_q) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wprec_q    <= '0;
      iprec_q    <= '0;
      wsigned_q  <= 1'b0;
      isigned_q  <= 1'b0;
      len_q      <= '0;
      wbase_q    <= '0;
      ibase_q    <= '0;
      raddr_q    <= '0;
      iaddr_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      clr_q      <= 1'b0;
      ird_q      <= 1'b0;
      sh_q       <= 1'b0;
      mulmode_q  <= MM_IDLE;
      iss_neg_q  <= 1'b0;
      iss_sh_q   <= 1'b0;
      iss_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wprec_q    <= wprec_d;
      iprec_q    <= iprec_d;
      wsigned_q  <= wsigned_d;
      isigned_q  <= isigned_d;
      len_q      <= len_d;
      wbase_q    <= wbase_d;
      ibase_q    <= ibase_d;
      raddr_q    <= raddr_d;
      iaddr_q    <= iaddr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      clr_q      <= clr_d;
      ird_q      <= ird_d;
      sh_q       <= sh_d;
      mulmode_q  <= mulmode_d;
      iss_neg_q  <= iss_neg_d;
      iss_sh_q   <= iss_sh_d;
      iss_last_q <= iss_last_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.Raddr   = raddr_q;
  assign bus.iaddr   = iaddr_q;
  assign bus.ird     = ird_q;
  assign bus.clr     = clr_q;
  assign bus.sh      = sh_q;
  assign bus.mulmode = mulmode_q;

endmodule

// File: tb/tb_mvu_seq.sv
// Bench for mvu_seq: directed jobs plus random jobs, checked against a loop-nest
// issue model and an end-to-end bit-serial MVU model vs. the integer dot product.
module tb_mvu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] wmem [512];
  logic [7:0] imem [512];
  logic [7:0] wd_q, id_q;
  longint     acc;
  int         rw [64];
  int         rx [64];

  mvu_seq_if #(.AW(9), .PW(4)) bus ();

  mvu_seq #(.AW(9), .PW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Bit-serial MVU stand-in: 8-lane chunk popcount, one-cycle BRAM latency.
  always @(posedge clk) begin
    wd_q <= wmem[bus.Raddr];
    id_q <= imem[bus.iaddr];
    if (bus.clr) begin
      acc <= 0;
    end else if (bus.mulmode == 2'b01) begin
      acc <= (bus.sh ? acc * 2 : acc) + longint'($countones(wd_q & id_q));
    end else if (bus.mulmode == 2'b10) begin
      acc <= (bus.sh ? acc * 2 : acc) - longint'($countones(wd_q & id_q));
    end else begin
      acc <= acc;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One job from the cycle start is raised; returns in the cycle after done.
  task automatic run_job(input int wp, input int ip, input bit ws, input bit is,
                         input int ln, input int wb, input int ib, input bit poke);
    int exp_ra[$], exp_ia[$], exp_mm[$], exp_sh[$];
    int obs_ra[$], obs_ia[$], obs_mm[$], obs_sh[$], iss_cyc[$], mm_cyc[$];
    int kmax, bm, jj, n, cyc_n, done_cyc, clr_cnt, busy_bad, sh_bad, limit, wm, im, raw;
    longint dot;
    kmax = wp + ip;
    for (int k = kmax; k >= 0; k--) begin
      bm = (k < wp) ? k : wp;
      for (int b = bm; b >= 0; b--) begin
        jj = k - b;
        if (jj > ip) break;
        for (int c = 0; c < ln; c++) begin
          exp_ra.push_back((wb + b * ln + c) % 512);
          exp_ia.push_back((ib + jj * ln + c) % 512);
          exp_sh.push_back((k != kmax && b == bm && c == 0) ? 1 : 0);
          exp_mm.push_back(((ws && b == wp) ^ (is && jj == ip)) ? 2 : 1);
        end
      end
    end
    n   = ln * 8;
    wm  = 1 << (wp + 1);
    im  = 1 << (ip + 1);
    dot = 0;
    for (int e = 0; e < n; e++) begin
      raw = int'($urandom % wm);
      rw[e] = raw;
      raw = int'($urandom % im);
      rx[e] = raw;
      dot += longint'((ws && rw[e] >= wm / 2) ? rw[e] - wm : rw[e]) *
             longint'((is && rx[e] >= im / 2) ? rx[e] - im : rx[e]);
    end
    for (int b = 0; b <= wp; b++)
      for (int c = 0; c < ln; c++)
        for (int e = 0; e < 8; e++)
          wmem[(wb + b * ln + c) % 512][e] = 1'((rw[c * 8 + e] >> b) & 1);
    for (int j = 0; j <= ip; j++)
      for (int c = 0; c < ln; c++)
        for (int e = 0; e < 8; e++)
          imem[(ib + j * ln + c) % 512][e] = 1'((rx[c * 8 + e] >> j) & 1);

    bus.wprec = 4'(wp); bus.iprec = 4'(ip); bus.wsigned = ws; bus.isigned = is;
    bus.len = 9'(ln); bus.wbase = 9'(wb); bus.ibase = 9'(ib);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.wprec = 4'($urandom); bus.iprec = 4'($urandom); bus.len = 9'($urandom);
    bus.wbase = 9'($urandom); bus.ibase = 9'($urandom);
    bus.wsigned = 1'($urandom); bus.isigned = 1'($urandom);
    cyc_n = 1; done_cyc = -1; clr_cnt = 0; busy_bad = 0; sh_bad = 0;
    limit = 3 + ln * (wp + 1) * (ip + 1) + 10;
    while (cyc_n < limit) begin
      if (bus.clr) clr_cnt += (cyc_n == 1) ? 1 : 100;
      if (bus.ird) begin
        obs_ra.push_back(int'(bus.Raddr)); obs_ia.push_back(int'(bus.iaddr));
        iss_cyc.push_back(cyc_n);
      end
      if (bus.mulmode != 2'b00) begin
        obs_mm.push_back(int'(bus.mulmode)); obs_sh.push_back(int'(bus.sh));
        mm_cyc.push_back(cyc_n);
      end else if (bus.sh) begin
        sh_bad++;
      end else begin
        sh_bad += 0;
      end
      if (bus.done) begin
        done_cyc = cyc_n;
        break;
      end
      if (!bus.busy) busy_bad++;
      bus.start = (poke && cyc_n == 3) ? 1'b1 : 1'b0;
      cyc();
      cyc_n++;
    end
    chk("done_cycle", done_cyc, 3 + ln * (wp + 1) * (ip + 1));
    chk("busy_at_done", bus.busy, 0);
    chk("busy_during_job", busy_bad, 0);
    chk("clr_once_cycle1", clr_cnt, 1);
    chk("sh_while_idle", sh_bad, 0);
    chk("issue_count", obs_ra.size(), exp_ra.size());
    chk("accum_count", obs_mm.size(), exp_mm.size());
    for (int i = 0; i < exp_ra.size(); i++) begin
      chk($sformatf("Raddr[%0d]", i), (i < obs_ra.size()) ? obs_ra[i] : -1, exp_ra[i]);
      chk($sformatf("iaddr[%0d]", i), (i < obs_ia.size()) ? obs_ia[i] : -1, exp_ia[i]);
      chk($sformatf("mulmode[%0d]", i), (i < obs_mm.size()) ? obs_mm[i] : -1, exp_mm[i]);
      chk($sformatf("sh[%0d]", i), (i < obs_sh.size()) ? obs_sh[i] : -1, exp_sh[i]);
      chk($sformatf("align[%0d]", i), (i < mm_cyc.size() && i < iss_cyc.size()) ?
          mm_cyc[i] - iss_cyc[i] : -1, 1);
    end
    chk("dot_product", acc, dot);
    bus.start = poke;
    cyc();
    bus.start = 1'b0;
    chk("done_single_pulse", bus.done, 0);
    chk("start_in_done_ignored", {bus.busy, bus.clr}, 0);
  endtask

  initial begin
    int dn;
    for (int a = 0; a < 512; a++) begin
      wmem[a] = 8'h00;
      imem[a] = 8'h00;
    end
    bus.start = 1'b0; bus.wprec = 4'd0; bus.iprec = 4'd0; bus.wsigned = 1'b0;
    bus.isigned = 1'b0; bus.len = 9'd0; bus.wbase = 9'd0; bus.ibase = 9'd0;
    cyc();
    cyc();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_Raddr", bus.Raddr, 0);
    chk("rst_iaddr", bus.iaddr, 0);
    chk("rst_ird", bus.ird, 0);
    chk("rst_clr", bus.clr, 0);
    chk("rst_sh", bus.sh, 0);
    chk("rst_mulmode", bus.mulmode, 0);
    rst_n = 1'b1;
    cyc();

    run_job(0, 0, 1'b0, 1'b0, 1, 5, 7, 1'b0);
    run_job(1, 1, 1'b0, 1'b0, 1, 0, 0, 1'b0);
    run_job(1, 1, 1'b1, 1'b1, 1, 0, 0, 1'b1);
    run_job(1, 2, 1'b0, 1'b0, 3, 510, 100, 1'b0);
    run_job(2, 1, 1'b1, 1'b0, 0, 33, 44, 1'b0);
    run_job(3, 3, 1'b1, 1'b1, 8, int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), 1'b1);
    for (int r = 0; r < 6; r++) begin
      run_job(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'($urandom),
              1'($urandom), int'($urandom_range(1, 8)), int'($urandom_range(0, 511)),
              int'($urandom_range(0, 511)), 1'($urandom));
    end

    bus.wprec = 4'd1; bus.iprec = 4'd1; bus.len = 9'd4; bus.wbase = 9'd3; bus.ibase = 9'd9;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    rst_n = 1'b0;
    cyc();
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_Raddr", bus.Raddr, 0);
    chk("abort_iaddr", bus.iaddr, 0);
    chk("abort_ird", bus.ird, 0);
    chk("abort_clr", bus.clr, 0);
    chk("abort_sh", bus.sh, 0);
    chk("abort_mulmode", bus.mulmode, 0);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      dn += int'(bus.done) + int'(bus.busy);
    end
    chk("abort_no_done", dn, 0);
    run_job(2, 2, 1'b0, 1'b1, 2, 200, 300, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
